// File: rtl/multi_tick_generator_pkg.sv
// Shared definitions for the multi-channel tick generator: rule priority
// encoding, default reset period and the channel-select width helper.
package multi_tick_generator_pkg;

  localparam int unsigned DEFAULT_RESET_PERIOD = 1;

  // Per-channel update rules, listed in priority order
  typedef enum logic [1:0] {
    RULE_WRITE  = 2'd0,
    RULE_HOLD   = 2'd1,
    RULE_EXPIRE = 2'd2,
    RULE_COUNT  = 2'd3
  } rule_e;

  // ceil(log2(n)) with a floor of 1, so a single channel still gets a select bit
  function automatic int unsigned clog2_min1(input int unsigned n);
    int unsigned r;
    r = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((33'd1 << i) < 33'(n)) r = i + 1;
    end
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/multi_tick_generator_tick_channel.sv
// One tick channel: programmable down-counter producing a one-cycle strobe,
// periodic or one-shot, with a run enable that freezes the phase.
module tick_channel
  import multi_tick_generator_pkg::*;
#(
  parameter int unsigned nrOfBits    = 16,
  parameter int unsigned resetPeriod = DEFAULT_RESET_PERIOD
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                wr,
  input  logic [nrOfBits-1:0] wrPeriod,
  input  logic                wrOneShot,
  input  logic                en,
  output logic                tick,
  output logic                run
);

  localparam logic [nrOfBits-1:0] RST_PERIOD =
    (resetPeriod == 0) ? nrOfBits'(1) : nrOfBits'(resetPeriod);

  logic [nrOfBits-1:0] period_q, period_d;
  logic [nrOfBits-1:0] count_q, count_d;
  logic                one_shot_q, one_shot_d;
  logic                run_q, run_d;
  logic                tick_q, tick_d;
  logic [nrOfBits-1:0] wr_period_c;
  rule_e               rule_c;

  // Rule selection and next-state; a zero period is promoted to one
  always_comb begin
    wr_period_c = (wrPeriod == '0) ? nrOfBits'(1) : wrPeriod;
    period_d    = period_q;
    count_d     = count_q;
    one_shot_d  = one_shot_q;
    run_d       = run_q;
    tick_d      = 1'b0;

    if (wr)                      rule_c = RULE_WRITE;
    else if (!en || !run_q)      rule_c = RULE_HOLD;
    else if (count_q == '0)      rule_c = RULE_EXPIRE;
    else                         rule_c = RULE_COUNT;

    case (rule_c)
      RULE_WRITE: begin
        period_d   = wr_period_c;
        one_shot_d = wrOneShot;
        count_d    = wr_period_c - nrOfBits'(1);
        run_d      = 1'b1;
      end
      RULE_HOLD: begin
        tick_d = 1'b0;
      end
      RULE_EXPIRE: begin
        tick_d  = 1'b1;
        count_d = period_q - nrOfBits'(1);
        if (one_shot_q) run_d = 1'b0;
      end
      default: begin
        count_d = count_q - nrOfBits'(1);
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      period_q   <= RST_PERIOD;
      count_q    <= '0;
      one_shot_q <= 1'b0;
      run_q      <= 1'b1;
      tick_q     <= 1'b0;
    end else begin
      period_q   <= period_d;
      count_q    <= count_d;
      one_shot_q <= one_shot_d;
      run_q      <= run_d;
      tick_q     <= tick_d;
    end
  end

  assign tick = tick_q;
  assign run  = run_q;

endmodule

// File: rtl/multi_tick_generator.sv
// Multi-channel tick generator: decodes configuration writes to one channel
// and replicates an independent tick_channel per output bit.
module multi_tick_generator
  import multi_tick_generator_pkg::*;
#(
  parameter  int unsigned nrOfBits     = 16,
  parameter  int unsigned nrOfChannels = 4,
  parameter  int unsigned resetPeriod  = DEFAULT_RESET_PERIOD,
  localparam int unsigned chanBits     = clog2_min1(nrOfChannels)
) (
  input  logic                    FPGAClock,
  input  logic                    FPGAResetN,
  input  logic                    cfgWrite,
  input  logic [chanBits-1:0]     cfgChannel,
  input  logic [nrOfBits-1:0]     cfgPeriod,
  input  logic                    cfgOneShot,
  input  logic [nrOfChannels-1:0] enable,
  output logic [nrOfChannels-1:0] FPGATick,
  output logic [nrOfChannels-1:0] running
);

  logic [nrOfChannels-1:0] wr_sel_c;

  // One-hot write select; selects beyond the last channel match nothing
  always_comb begin
    wr_sel_c = '0;
    for (int unsigned i = 0; i < nrOfChannels; i++) begin
      wr_sel_c[i] = cfgWrite && (cfgChannel == chanBits'(i));
    end
  end

  for (genvar g = 0; g < int'(nrOfChannels); g++) begin : g_chan
    tick_channel #(
      .nrOfBits    (nrOfBits),
      .resetPeriod (resetPeriod)
    ) u_chan (
      .clk       (FPGAClock),
      .rst_n     (FPGAResetN),
      .wr        (wr_sel_c[g]),
      .wrPeriod  (cfgPeriod),
      .wrOneShot (cfgOneShot),
      .en        (enable[g]),
      .tick      (FPGATick[g]),
      .run       (running[g])
    );
  end

endmodule

// File: doc/multi_tick_generator.md
# multi_tick_generator

Parametrised, multi-channel successor to the single-rate FPGA tick generator. Each of `nrOfChannels` independent channels divides `FPGAClock` by a period programmable at run time. Each channel can run periodic or one-shot and has its own enable. It sits between the board clock and the simulated-clock and timer logic, giving several one-cycle tick strobes from one module.

## Interface
Parameters:
- `nrOfBits`, 16: width of each channel's period and counter.
- `nrOfChannels`, 4: number of channels, at least 1.
- `resetPeriod`, 1: period loaded into every channel on reset. A value of 0 is treated as 1.
- `chanBits`, derived: ceil(log2(`nrOfChannels`)), minimum 1. Not user-set.

Ports:
- `FPGAClock`  in  1: sole clock, rising edge.
- `FPGAResetN`  in  1: reset, asynchronous and active-low.
- `cfgWrite`  in  1: one-cycle configuration strobe.
- `cfgChannel`  in  `chanBits`: channel selected by `cfgWrite`.
- `cfgPeriod`  in  `nrOfBits`: new period P in cycles. 0 is treated as 1.
- `cfgOneShot`  in  1: 1 selects one-shot mode, 0 selects periodic mode.
- `enable`  in  `nrOfChannels`: per-channel run enable.
- `FPGATick`  out  `nrOfChannels`: registered tick strobe per channel.
- `running`  out  `nrOfChannels`: 1 while the channel is armed to tick.

## Operation
- Per-channel state:
  - `period` reg: `nrOfBits`.
  - `count` reg: `nrOfBits`.
  - `oneShot`: 1 bit.
  - `run`: 1 bit.
  - `tick`: 1 bit.
- Values while `FPGAResetN`=0, applied immediately:
  - `period` = max(`resetPeriod`,1).
  - `count` = 0.
  - `oneShot` = 0.
  - `run` = 1.
  - `tick` = 0.
- Outputs during reset: `FPGATick` = 0 and `running` = all ones.
- Per channel i at each rising edge, first matching rule wins:
  1. Write: `cfgWrite`=1 and `cfgChannel`=i.
     - `period` <= max(`cfgPeriod`,1), `oneShot` <= `cfgOneShot`.
     - `count` <= max(`cfgPeriod`,1)-1, `run` <= 1, `tick` <= 0.
     - This is a restart and applies regardless of `enable`[i].
  2. Hold: `enable`[i]=0 or `run`=0.
     - `tick` <= 0. `count` and `run` hold.
  3. Expire: `count`=0.
     - `tick` <= 1, `count` <= `period`-1.
     - If `oneShot`=1, also `run` <= 0.
  4. Count: otherwise `tick` <= 0, `count` <= `count`-1.
- Out-of-range writes: `cfgChannel` >= `nrOfChannels` is ignored. Every channel then follows rules 2–4.
- Channel independence: a write to one channel never disturbs another channel's count, phase or tick.
- Counter arithmetic is unsigned `nrOfBits`. Decrement never wraps, because rule 3 intercepts 0.
- Maximum period is 2^`nrOfBits`-1.
- Outputs: `FPGATick`[i] = `tick`, `running`[i] = `run`. Both come straight from registers with no combinational path from the inputs.

## Timing
- First tick after write: a write at edge k with `enable` held high gives the first `FPGATick` pulse after edge k+P, lasting exactly one cycle.
- Periodic mode: subsequent pulses follow after edges k+2P, k+3P, and so on.
- P=1: `FPGATick` stays high every cycle after edge k+1.
- After reset: `count`=0, so the first pulse follows the first enabled edge. This matches the legacy single-channel behaviour.
- Enable low: the phase freezes. Re-raising `enable` resumes the count where it stopped, with no lost or extra ticks.
- One-shot: exactly one pulse. `running` falls at the same edge that raises `FPGATick`. The channel then stays silent until the next write.
- Write coinciding with expiry: the write wins. No pulse is produced that cycle and the period restarts.
- Reset mid-operation: asynchronous assertion forces all outputs to their reset values immediately. Deassertion is expected to be synchronised externally.

## Structure
- Shared package or header holds:
  - the `clog2` helper with minimum 1, used for `chanBits`;
  - the rule-priority encoding constants;
  - the default `resetPeriod`.
- Sub-module: `tick_channel` holds one channel's registers and rules 1–4. It has ports clock, reset, `wr`, `wrPeriod`, `wrOneShot`, `en`, `tick` and `run`.
- The top level decodes `cfgChannel` into a one-hot write vector and instantiates `nrOfChannels` copies of `tick_channel` in a generate loop.

## Test plan
- Reset then periodic default: `resetPeriod`=3, enable all. Required: ticks after edges 1, 4, 7 and 10, and `running`=1111 throughout.
- Periodic programming: write ch1 P=5 at edge 10. Required: ch1 pulses after edges 15, 20 and 25, with ch0, ch2 and ch3 timing unchanged.
- One-shot: write ch2 P=4 with `cfgOneShot`=1 at edge 20. Required: one pulse after edge 24, `running`[2] falls at edge 24, and no further pulses over 50 cycles.
- Enable freeze: ch0 P=6 written at edge 0, `enable`[0] low during edges 3–7 inclusive. Required: the pulse that would have followed edge 6 instead follows edge 11.
- Boundary: write P=0 to ch3. Required: behaves as P=1, pulsing every cycle. A write coinciding with expiry produces no pulse that cycle and restarts the count.
- Out-of-range and async reset:
  - With `nrOfChannels`=3, a write to channel 3 changes nothing.
  - Asserting `FPGAResetN` low mid-count clears `FPGATick` before the next edge.
  - After release, all channels restart with `resetPeriod`.
